// File: rtl/rgb_compositeur.sv
// Priority compositor for N_COUCHES colour-code layers. A palette RAM maps the winning code to RRRGGGBB.
// Optional palette readback port, enabled by defining RGB_PAL_READBACK_EN.
module rgb_compositeur #(
  parameter int N_COUCHES = 3,
  parameter int CODE_W    = 5
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [N_COUCHES*CODE_W-1:0]        couleurs,
  input  logic                               pix_valid,
  input  logic                               pal_we,
  input  logic [CODE_W-1:0]                  pal_addr,
  input  logic [7:0]                         pal_data,
  output logic                               pal_ready,
  output logic [2:0]                         rouge,
  output logic [2:0]                         vert,
  output logic [1:0]                         bleu,
  output logic                               rgb_valid,
  output logic [$clog2(N_COUCHES+1)-1:0]     couche_active
`ifdef RGB_PAL_READBACK_EN
  ,
  input  logic                               pal_re,
  output logic [7:0]                         pal_rdata
`endif
);

  localparam int IDX_W = $clog2(N_COUCHES + 1);
  localparam int DEPTH = 2 ** CODE_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   init_addr_q, init_addr_d;

  logic [7:0]          pal_mem [DEPTH];
  logic                wr_en;
  logic [CODE_W-1:0]   wr_addr;
  logic [7:0]          wr_data;
  logic                user_wr;
  logic [2:0]          init_k;

  logic [CODE_W-1:0]   win_code;
  logic [IDX_W-1:0]    win_idx;
  logic [CODE_W-1:0]   code1_q, code1_d;
  logic [IDX_W-1:0]    idx1_q;
  logic                vld1_q;

  logic [7:0]          rd_data;
  logic [7:0]          pix_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + CODE_W'(1);
        if (init_addr_q == CODE_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d     = ST_INIT;
        init_addr_d = '0;
      end
    endcase
  end

  assign pal_ready = (state_q == ST_RUN);
  assign user_wr   = pal_we && pal_ready;
  // Default entry replicates the low address bits into each colour field.
  assign init_k    = 3'(init_addr_q);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = pal_addr;
    wr_data = pal_data;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = init_addr_q;
      wr_data = {init_k, init_k, init_k[1:0]};
    end else if (user_wr) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      pal_mem[wr_addr] <= wr_data;
    end
  end

  // Lowest layer index with a nonzero code wins; scanning downward lets it overwrite the rest.
  always_comb begin
    win_code = '0;
    win_idx  = IDX_W'(N_COUCHES);
    for (int i = N_COUCHES - 1; i >= 0; i--) begin
      if (couleurs[i*CODE_W +: CODE_W] != '0) begin
        win_code = couleurs[i*CODE_W +: CODE_W];
        win_idx  = IDX_W'(i);
      end
    end
  end

  assign code1_d = pix_valid ? win_code : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      code1_q <= '0;
      idx1_q  <= '0;
      vld1_q  <= 1'b0;
    end else begin
      code1_q <= code1_d;
      idx1_q  <= win_idx;
      vld1_q  <= pix_valid;
    end
  end

  // Write-first: a same-edge write to the address being read is forwarded.
  assign rd_data = (user_wr && (pal_addr == code1_q)) ? pal_data : pal_mem[code1_q];
  assign pix_d   = (pal_ready && (code1_q != '0)) ? rd_data : 8'h00;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rouge         <= '0;
      vert          <= '0;
      bleu          <= '0;
      rgb_valid     <= 1'b0;
      couche_active <= '0;
    end else begin
      rouge         <= pix_d[7:5];
      vert          <= pix_d[4:2];
      bleu          <= pix_d[1:0];
      rgb_valid     <= vld1_q;
      couche_active <= pal_ready ? idx1_q : '0;
    end
  end

`ifdef RGB_PAL_READBACK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pal_rdata <= 8'h00;
    end else if (pal_re && pal_ready) begin
      pal_rdata <= user_wr ? pal_data : pal_mem[pal_addr];
    end
  end
`endif

endmodule

// File: tb/tb_rgb_compositeur.sv
// Directed bench for rgb_compositeur: default instance plus a 5-layer, 3-bit-code instance.
module tb_rgb_compositeur;

  logic        clk;
  logic        reset_n;
  logic [14:0] couleurs;
  logic        pix_valid;
  logic        pal_we;
  logic [4:0]  pal_addr;
  logic [7:0]  pal_data;
  logic        pal_ready;
  logic [2:0]  rouge, vert;
  logic [1:0]  bleu;
  logic        rgb_valid;
  logic [1:0]  couche_active;

  logic [14:0] couleurs2;
  logic        pal_ready2;
  logic [2:0]  rouge2, vert2;
  logic [1:0]  bleu2;
  logic        rgb_valid2;
  logic [2:0]  couche_active2;

`ifdef RGB_PAL_READBACK_EN
  logic        pal_re;
  logic [7:0]  pal_rdata;
  logic [7:0]  pal_rdata2;
`endif

  int checks = 0;
  int passes = 0;

  rgb_compositeur dut (
    .clk(clk), .reset_n(reset_n), .couleurs(couleurs), .pix_valid(pix_valid),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data), .pal_ready(pal_ready),
    .rouge(rouge), .vert(vert), .bleu(bleu), .rgb_valid(rgb_valid),
    .couche_active(couche_active)
`ifdef RGB_PAL_READBACK_EN
    , .pal_re(pal_re), .pal_rdata(pal_rdata)
`endif
  );

  rgb_compositeur #(.N_COUCHES(5), .CODE_W(3)) dut5 (
    .clk(clk), .reset_n(reset_n), .couleurs(couleurs2), .pix_valid(1'b1),
    .pal_we(1'b0), .pal_addr(3'd0), .pal_data(8'h00), .pal_ready(pal_ready2),
    .rouge(rouge2), .vert(vert2), .bleu(bleu2), .rgb_valid(rgb_valid2),
    .couche_active(couche_active2)
`ifdef RGB_PAL_READBACK_EN
    , .pal_re(1'b0), .pal_rdata(pal_rdata2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset;
    int cnt, cnt5, bad;
    reset_n   = 1'b0;
    couleurs  = {5'd9, 5'd10, 5'd11};
    couleurs2 = {3'd2, 3'd6, 3'd0, 3'd0, 3'd0};
    pix_valid = 1'b1;
    pal_we    = 1'b0;
    pal_addr  = '0;
    pal_data  = '0;
`ifdef RGB_PAL_READBACK_EN
    pal_re    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (pal_ready !== 1'b0) $display("[TB] FAIL reset_pal_ready: got %b expected 0", pal_ready);
    else passes++;
    checks++;
    if ({rouge, vert, bleu, rgb_valid, couche_active} !== 11'd0)
      $display("[TB] FAIL reset_outputs: got %h expected 0", {rouge, vert, bleu, rgb_valid, couche_active});
    else passes++;
    reset_n = 1'b1;
    cnt = 0; cnt5 = 0; bad = 0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (pal_ready2 === 1'b1 && cnt5 == 0) cnt5 = cnt;
      if (pal_ready === 1'b1) break;
      if ({rouge, vert, bleu} !== 8'h00) bad++;
    end
    checks++;
    if (cnt !== 32) $display("[TB] FAIL init_cycles: got %0d expected 32", cnt);
    else passes++;
    checks++;
    if (cnt5 !== 8) $display("[TB] FAIL init_cycles_5x3: got %0d expected 8", cnt5);
    else passes++;
    checks++;
    if (bad !== 0) $display("[TB] FAIL init_outputs_zero: got %0d nonzero cycles expected 0", bad);
    else passes++;
  endtask

  task automatic test_priority;
    logic [14:0] vec [4];
    logic [7:0]  exp_rgb [4];
    logic [1:0]  exp_idx [4];
    vec[0] = {5'd9, 5'd10, 5'd11}; exp_rgb[0] = {3'd3, 3'd3, 2'd3}; exp_idx[0] = 2'd0;
    vec[1] = {5'd9, 5'd10, 5'd0};  exp_rgb[1] = {3'd2, 3'd2, 2'd2}; exp_idx[1] = 2'd1;
    vec[2] = {5'd9, 5'd0,  5'd0};  exp_rgb[2] = {3'd1, 3'd1, 2'd1}; exp_idx[2] = 2'd2;
    vec[3] = {5'd0, 5'd0,  5'd0};  exp_rgb[3] = 8'h00;               exp_idx[3] = 2'd3;
    pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      couleurs = vec[i];
      repeat (2) @(negedge clk);
      checks++;
      if ({rouge, vert, bleu} !== exp_rgb[i])
        $display("[TB] FAIL priority_rgb[%0d]: got %h expected %h", i, {rouge, vert, bleu}, exp_rgb[i]);
      else passes++;
      checks++;
      if (couche_active !== exp_idx[i])
        $display("[TB] FAIL priority_idx[%0d]: got %0d expected %0d", i, couche_active, exp_idx[i]);
      else passes++;
      checks++;
      if (rgb_valid !== 1'b1) $display("[TB] FAIL priority_valid[%0d]: got %b expected 1", i, rgb_valid);
      else passes++;
    end
  endtask

  task automatic test_blanking;
    logic pat [8];
    pat[0] = 0; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1; pat[5] = 0; pat[6] = 0; pat[7] = 0;
    couleurs  = {5'd9, 5'd10, 5'd11};
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rouge, vert, bleu, rgb_valid} !== 9'd0)
      $display("[TB] FAIL blank_outputs: got %h expected 0", {rouge, vert, bleu, rgb_valid});
    else passes++;
    for (int j = 0; j < 8; j++) begin
      if (j >= 2) begin
        checks++;
        if (rgb_valid !== pat[j-2])
          $display("[TB] FAIL valid_shift[%0d]: got %b expected %b", j, rgb_valid, pat[j-2]);
        else passes++;
      end
      pix_valid = pat[j];
      @(negedge clk);
    end
    pix_valid = 1'b1;
  endtask

  task automatic test_palette_write;
    couleurs = {5'd0, 5'd0, 5'd11};
    pal_we = 1'b1; pal_addr = 5'd11; pal_data = 8'hE3;
    @(negedge clk);
    pal_we = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rouge, vert, bleu} !== {3'd7, 3'd0, 2'd3})
      $display("[TB] FAIL write_e3: got %h expected e3", {rouge, vert, bleu});
    else passes++;
    // Back-to-back writes to entry 12: 8'h11 then 8'hFF.
    couleurs = {5'd0, 5'd12, 5'd0};
    pal_we = 1'b1; pal_addr = 5'd12; pal_data = 8'h11;
    @(negedge clk);
    pal_data = 8'hFF;
    @(negedge clk);
    pal_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({rouge, vert, bleu} !== 8'hFF)
      $display("[TB] FAIL last_write_wins: got %h expected ff", {rouge, vert, bleu});
    else passes++;
    checks++;
    if (couche_active !== 2'd1) $display("[TB] FAIL write_idx: got %0d expected 1", couche_active);
    else passes++;
    // Entry 0 filled with FF must still show black.
    pal_we = 1'b1; pal_addr = 5'd0; pal_data = 8'hFF;
    couleurs = '0;
    @(negedge clk);
    pal_we = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rouge, vert, bleu} !== 8'h00)
      $display("[TB] FAIL code0_black: got %h expected 00", {rouge, vert, bleu});
    else passes++;
  endtask

  task automatic test_collision;
    couleurs = {5'd0, 5'd0, 5'd11};
    pal_we = 1'b1; pal_addr = 5'd11; pal_data = 8'h49;
    @(negedge clk);
    pal_we = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rouge, vert, bleu} !== 8'h49)
      $display("[TB] FAIL pre_collision: got %h expected 49", {rouge, vert, bleu});
    else passes++;
    pal_we = 1'b1; pal_addr = 5'd11; pal_data = 8'hE3;
    @(negedge clk);
    pal_we = 1'b0;
    checks++;
    if ({rouge, vert, bleu} !== 8'hE3)
      $display("[TB] FAIL write_first: got %h expected e3", {rouge, vert, bleu});
    else passes++;
  endtask

  task automatic test_reset_mid;
    int cnt;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (17) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (pal_ready !== 1'b0) $display("[TB] FAIL mid_reset_ready: got %b expected 0", pal_ready);
    else passes++;
    reset_n = 1'b1;
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (cnt == 20) begin
        pal_we = 1'b1; pal_addr = 5'd5; pal_data = 8'hFF;
      end
      if (cnt == 21) pal_we = 1'b0;
      if (pal_ready === 1'b1) break;
    end
    pal_we = 1'b0;
    checks++;
    if (cnt !== 32) $display("[TB] FAIL mid_reset_init_cycles: got %0d expected 32", cnt);
    else passes++;
    pix_valid = 1'b1;
    couleurs = {5'd0, 5'd0, 5'd11};
    repeat (2) @(negedge clk);
    checks++;
    if ({rouge, vert, bleu} !== 8'h6F)
      $display("[TB] FAIL entry11_default: got %h expected 6f", {rouge, vert, bleu});
    else passes++;
    couleurs = {5'd0, 5'd0, 5'd5};
    repeat (2) @(negedge clk);
    checks++;
    if ({rouge, vert, bleu} !== 8'hB5)
      $display("[TB] FAIL init_write_dropped: got %h expected b5", {rouge, vert, bleu});
    else passes++;
  endtask

  task automatic test_params_5x3;
    couleurs2 = {3'd2, 3'd6, 3'd0, 3'd0, 3'd0};
    repeat (2) @(negedge clk);
    checks++;
    if ({rouge2, vert2, bleu2} !== 8'b110_110_10)
      $display("[TB] FAIL p5_rgb: got %h expected da", {rouge2, vert2, bleu2});
    else passes++;
    checks++;
    if (couche_active2 !== 3'd3) $display("[TB] FAIL p5_idx: got %0d expected 3", couche_active2);
    else passes++;
  endtask

`ifdef RGB_PAL_READBACK_EN
  task automatic test_readback;
    pal_re = 1'b1; pal_addr = 5'd9;
    @(negedge clk);
    pal_re = 1'b0;
    checks++;
    if (pal_rdata !== 8'b001_001_01) $display("[TB] FAIL readback_9: got %h expected 25", pal_rdata);
    else passes++;
    pal_re = 1'b1; pal_we = 1'b1; pal_addr = 5'd13; pal_data = 8'hA5;
    @(negedge clk);
    pal_re = 1'b0; pal_we = 1'b0; pal_addr = 5'd9;
    checks++;
    if (pal_rdata !== 8'hA5) $display("[TB] FAIL readback_wr: got %h expected a5", pal_rdata);
    else passes++;
    @(negedge clk);
    checks++;
    if (pal_rdata !== 8'hA5) $display("[TB] FAIL readback_hold: got %h expected a5", pal_rdata);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_priority();
    test_blanking();
    test_palette_write();
    test_collision();
    test_reset_mid();
    test_params_5x3();
`ifdef RGB_PAL_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rgb_compositeur.md
Name: rgb_compositeur

Overview:
- Parametrised, pipelined successor to the three-input Rgb colour mux.
- Composites N_COUCHES layer colour codes with fixed priority; layer 0 wins over higher indices, and code 0 means transparent.
- Maps the winning code through a writable palette RAM to the 8-bit RRRGGGBB VGA bus.
- Sits between the game-object renderers (pave, pesanteur, cadre, ...) and the VGA output stage.

Parameters:
- N_COUCHES, 3, number of layers composited; index 0 has the highest priority.
- CODE_W, 5, width of each colour code; the palette has 2^CODE_W entries.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- couleurs  in  N_COUCHES*CODE_W  layer i occupies bits [i*CODE_W +: CODE_W]
- pix_valid  in  1  pixel is inside the visible area
- pal_we  in  1  palette write strobe
- pal_addr  in  CODE_W  palette write address
- pal_data  in  8  palette entry as {R[2:0],G[2:0],B[1:0]}
- pal_ready  out  1  palette init finished; writes are accepted
- rouge  out  3  red
- vert  out  3  green
- bleu  out  2  blue
- rgb_valid  out  1  pix_valid delayed by 2 cycles
- couche_active  out  max(1,$clog2(N_COUCHES+1))  winning layer index; N_COUCHES when no layer is opaque

Behaviour:
- Reset and init
  - Reset is synchronous on reset_n low: all outputs are 0, pal_ready=0, pipeline registers are cleared, and the FSM enters INIT with init_addr=0.
  - FSM state INIT: each cycle writes default(init_addr) into the palette, then increments init_addr. After 2^CODE_W cycles it enters RUN and sets pal_ready=1.
  - default(k) = {k[2:0], k[2:0], k[1:0]}, with k zero-extended when CODE_W<3. Entry 0 is 8'h00.
  - FSM state RUN: the palette is written on pal_we. pal_we is ignored while pal_ready=0.
  - reset_n low during INIT restarts INIT from address 0.
- Pipeline (latency 2 cycles, one pixel per cycle, no stall)
  - Stage 1 registers: code of the lowest-index layer with a nonzero code, the winning index, and pix_valid.
    - If every layer is 0: code=0, index=N_COUCHES.
    - If pix_valid=0: the stage is forced to code 0.
  - Stage 2 registers: palette[code] onto rouge, vert, bleu; rgb_valid and couche_active are delayed from stage 1.
  - Code 0 always produces 000/000/00, regardless of the palette[0] contents.
  - Outputs are forced to 0 while pal_ready=0; rgb_valid still propagates.
- Palette write/read collision: write-first. If pal_we targets the address being read in stage 2 on the same edge, the output shows pal_data.
- Back-to-back writes to the same address: the last write wins.

Optional Feature:
- Macro: RGB_PAL_READBACK_EN.
- When defined:
  - Adds ports pal_re (in, 1) and pal_rdata (out, 8).
  - pal_rdata = palette[pal_addr] one cycle after pal_re=1. It holds its value otherwise and resets to 0.
  - pal_re together with pal_we on the same address returns the new data.
  - pal_re is ignored during INIT.
- When undefined: the ports are absent and there is no read path.

Test Plan:
- Reset, init timing: hold reset_n=0 for 3 cycles, then release. pal_ready rises exactly 32 cycles later with default params. Outputs stay 0 throughout.
- Priority with default params, pix_valid=1:
  - layer0=11, layer1=10, layer2=9 -> 2 cycles later rouge=3, vert=3, bleu=3, couche_active=0.
  - layer0=0 -> 2,2,2, couche_active=1.
  - layer1=0 -> 1,1,1, couche_active=2.
  - layer2=0 -> 0,0,0, couche_active=3.
- Blanking: layers=11/10/9 with pix_valid=0 -> rgb output 0 and rgb_valid=0 two cycles later. A pix_valid pulse pattern of 1,0,1 reappears on rgb_valid shifted by 2.
- Palette write:
  - Write addr 11 = 8'hE3 -> subsequent layer0=11 gives rouge=7, vert=0, bleu=3.
  - A write to addr 11 on the same edge as its stage-2 read shows 8'hE3 immediately.
  - pal_we during INIT is dropped; the entry keeps its default value.
- Reset mid-operation: assert reset_n=0 at init_addr=17, then release. Entry 11 is restored to its default, and pal_ready rises 32 cycles after release.
- N_COUCHES=5, CODE_W=3: layers {0,0,0,6,2} -> default(6)=8'b110_110_10 gives rouge=6, vert=6, bleu=2, couche_active=3. Init lasts 8 cycles.
- With RGB_PAL_READBACK_EN defined: pal_re at addr 9 after init -> pal_rdata=8'b001_001_01 one cycle later.
